text_console_writer: RTL

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer_pkg.sv | 23 ++
 rtl/text_console_writer_if.sv | 25 ++
 rtl/text_console_writer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/text_console_writer_pkg.sv
// Shared constants and state type for the text console writer.
// Holds default geometry, control-code values and the FSM state enum.
package console_pkg;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 30;
  localparam logic [7:0]  DEF_ATTR = 8'h07;

  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic [1:0] {
    StClearScreen,
    StIdle,
    StEsc,
    StClearRow
  } state_e;

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream input and text-buffer write port of the console writer.
// The slave side is the writer; the master side is the byte source / observer.
interface text_console_writer_if;
  logic [7:0]  char_in;
  logic        valid_in;
  logic        ready_out;
  logic        we_out;
  logic [11:0] addr_out;
  logic [15:0] data_out;
  logic [6:0]  cursor_col_out;
  logic [4:0]  cursor_row_out;
  logic [4:0]  top_row_out;

  modport slave (
    input  char_in, valid_in,
    output ready_out, we_out, addr_out, data_out,
    output cursor_col_out, cursor_row_out, top_row_out
  );

  modport master (
    output char_in, valid_in,
    input  ready_out, we_out, addr_out, data_out,
    input  cursor_col_out, cursor_row_out, top_row_out
  );
endinterface

// File: rtl/text_console_writer.sv
// Converts a byte stream into writes to a ROWS x COLS text buffer, handling
// CR/LF/BS/FF, ESC-prefixed attribute changes, scrolling and screen/row clears.
module text_console_writer
  import console_pkg::*;
#(
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter logic [7:0]  DEFAULT_ATTR = DEF_ATTR
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  text_console_writer_if.slave  bus
);

  localparam logic [6:0]  LastCol  = 7'(COLS - 1);
  localparam logic [4:0]  LastRow  = 5'(ROWS - 1);
  localparam logic [11:0] ColsW    = 12'(COLS);
  localparam logic [11:0] LastCell = 12'(ROWS * COLS - 1);

  state_e      state_q;
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  logic [11:0] row_base_q;
  logic [7:0]  attr_q;
  logic        wrapped_q;
  logic [11:0] clr_addr_q;
  logic [6:0]  clr_col_q;
  logic        we_q;
  logic [11:0] addr_q;
  logic [15:0] data_q;

  logic        ready;
  logic        accept;
  logic        is_ctrl;
  logic [11:0] cur_addr;
  logic [11:0] prev_addr;
  logic [4:0]  next_row;
  logic [11:0] next_base;

  // row_base_q tracks row*COLS incrementally, so no multiplier is needed
  always_comb begin
    ready     = (state_q == StIdle) || (state_q == StEsc);
    accept    = bus.valid_in && ready;
    is_ctrl   = (bus.char_in < BLANK);
    cur_addr  = row_base_q + {5'd0, col_q};
    prev_addr = cur_addr - 12'd1;
    next_row  = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
    next_base = (row_q == LastRow) ? 12'd0 : row_base_q + ColsW;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StClearScreen;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      attr_q     <= DEFAULT_ATTR;
      wrapped_q  <= 1'b0;
      clr_addr_q <= '0;
      clr_col_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StClearScreen: begin
          we_q       <= 1'b1;
          addr_q     <= clr_addr_q;
          data_q     <= {attr_q, BLANK};
          clr_addr_q <= clr_addr_q + 12'd1;
          if (clr_addr_q == LastCell) begin
            state_q <= StIdle;
          end
        end
        StClearRow: begin
          we_q      <= 1'b1;
          addr_q    <= row_base_q + {5'd0, clr_col_q};
          data_q    <= {attr_q, BLANK};
          clr_col_q <= clr_col_q + 7'd1;
          if (clr_col_q == LastCol) begin
            state_q <= StIdle;
          end
        end
        StEsc: begin
          if (accept) begin
            attr_q  <= bus.char_in;
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (accept) begin
            case (bus.char_in)
              CR: col_q <= '0;
              LF: begin
                col_q      <= '0;
                row_q      <= next_row;
                row_base_q <= next_base;
                clr_col_q  <= '0;
                state_q    <= StClearRow;
                if (row_q == LastRow) wrapped_q <= 1'b1;
              end
              BS: begin
                if (col_q != '0) begin
                  col_q  <= col_q - 7'd1;
                  we_q   <= 1'b1;
                  addr_q <= prev_addr;
                  data_q <= {attr_q, BLANK};
                end
              end
              FF: begin
                col_q      <= '0;
                row_q      <= '0;
                row_base_q <= '0;
                wrapped_q  <= 1'b0;
                clr_addr_q <= '0;
                state_q    <= StClearScreen;
              end
              ESC: state_q <= StEsc;
              default: begin
                // Remaining control codes are swallowed without effect
                if (!is_ctrl) begin
                  we_q   <= 1'b1;
                  addr_q <= cur_addr;
                  data_q <= {attr_q, bus.char_in};
                  if (col_q == LastCol) begin
                    col_q      <= '0;
                    row_q      <= next_row;
                    row_base_q <= next_base;
                    clr_col_q  <= '0;
                    state_q    <= StClearRow;
                    if (row_q == LastRow) wrapped_q <= 1'b1;
                  end else begin
                    col_q <= col_q + 7'd1;
                  end
                end
              end
            endcase
          end
        end
        default: state_q <= StClearScreen;
      endcase
    end
  end

  assign bus.ready_out      = ready;
  assign bus.we_out         = we_q;
  assign bus.addr_out       = addr_q;
  assign bus.data_out       = data_q;
  assign bus.cursor_col_out = col_q;
  assign bus.cursor_row_out = row_q;
  assign bus.top_row_out    = !wrapped_q ? 5'd0 : next_row;

endmodule
